// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle control unit for the CPU datapath.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It latches the decoder's control word and turns it into one-cycle phase strobes.
// It owns the memory bus and lends it to the DMA engine only between instructions.
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [5:0]      opcode,
    input  logic [19:0]     ctrl_word,
    input  logic [PC_W-1:0] alu_result,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            alu_en,
    output logic            reg_wr_en,
    input  logic            dma_hold,
    output logic            dma_hlda,
    output logic [2:0]      state,
    output logic            fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // The last count value that is still tolerated before the bus is declared dead.
    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    logic [2:0]      state_q;
    logic [2:0]      next_state;
    logic [2:0]      boundary_state;
    logic [31:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] addr_q;
    logic [19:0]     ctrl_q;
    logic [3:0]      tmo_cnt;
    logic            hlda_q;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
    logic            bus_active;
    logic            timed_out;
    logic            unused_ctrl_bits;

    assign mem_rd = |ctrl_q[15:12];
    assign mem_wr = |ctrl_q[11:8];
    assign reg_wr = |ctrl_q[3:0];

    // These control-word fields steer other datapath blocks, not the sequencer.
    assign unused_ctrl_bits = ^{ctrl_q[19:16], ctrl_q[7:4]};

    assign bus_active = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timed_out  = bus_active && !mem_ack && (tmo_cnt == TMO_LAST);

    // Next-state logic. The boundary choice puts DMA first, then run/idle.
    always_comb begin
        boundary_state = S_FETCH;
        if (dma_hold) begin
            boundary_state = S_HOLD;
        end else if (!run) begin
            boundary_state = S_IDLE;
        end

        next_state = state_q;
        case (state_q)
            S_IDLE:   next_state = boundary_state;
            S_FETCH: begin
                if (mem_ack) begin
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (mem_rd || mem_wr) begin
                    next_state = S_MEM;
                end else if (reg_wr) begin
                    next_state = S_WB;
                end else begin
                    next_state = boundary_state;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    next_state = reg_wr ? S_WB : boundary_state;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end
            end
            S_WB:     next_state = boundary_state;
            S_HOLD:   next_state = hlda_q ? S_HOLD : boundary_state;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_IDLE;
        endcase
    end

    // State and datapath registers. An asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            tmo_cnt <= '0;
            hlda_q  <= 1'b0;
        end else begin
            state_q <= next_state;

            if (state_q == S_FETCH && mem_ack) begin
                ir_q <= mem_rdata;
                pc_q <= pc_q + 1'b1;
            end

            if (state_q == S_DECODE) begin
                ctrl_q <= ctrl_word;
            end

            // The data address is captured once so it stays stable for the whole MEM wait.
            if (state_q == S_EXEC) begin
                addr_q <= alu_result;
            end

            if ((next_state == S_FETCH || next_state == S_MEM) && next_state != state_q) begin
                tmo_cnt <= '0;
            end else if (bus_active && !mem_ack) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end

            // The grant is held while the DMA engine asks for it. When the request drops,
            // the grant falls first, and the FSM leaves HOLD one cycle later.
            if (state_q == S_HOLD && hlda_q) begin
                hlda_q <= dma_hold;
            end else begin
                hlda_q <= (next_state == S_HOLD);
            end
        end
    end

    assign state     = state_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign opcode    = ir_q[31:26];
    assign mem_req   = bus_active;
    assign mem_we    = (state_q == S_MEM) && mem_wr;
    assign mem_addr  = (state_q == S_FETCH) ? pc_q :
                       (state_q == S_MEM)   ? addr_q : '0;
    assign alu_en    = (state_q == S_EXEC);
    assign reg_wr_en = (state_q == S_WB);
    assign dma_hlda  = hlda_q;
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed test of the instruction sequencer.
// Memory is modelled with a programmable number of wait cycles.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode;
    logic [19:0] ctrl_word = '0;
    logic [7:0]  alu_result = '0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ir;
    logic [7:0]  pc;
    logic        alu_en;
    logic        reg_wr_en;
    logic        dma_hold = 1'b0;
    logic        dma_hlda;
    logic [2:0]  state;
    logic        fault;

    int assertCount = 0;
    int failCount   = 0;
    int ackDelay    = 0;
    int waitCnt     = 0;
    logic ackOn     = 1'b1;

    instr_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .ctrl_word(ctrl_word), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .pc(pc),
        .alu_en(alu_en), .reg_wr_en(reg_wr_en), .dma_hold(dma_hold),
        .dma_hlda(dma_hlda), .state(state), .fault(fault)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Memory model: ack after ackDelay wait cycles; never acks without a request
    assign mem_ack = mem_req && ackOn && (waitCnt >= ackDelay);

    // Count wait cycles of the current request
    always @(posedge clk) begin
        waitCnt <= (mem_req && !mem_ack) ? waitCnt + 1 : 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic [19:0] cw, input logic [7:0] alu);
        run        = r;
        dma_hold   = h;
        ctrl_word  = cw;
        alu_result = alu;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 20'h0, 8'h0);
        ackDelay = 0;
        ackOn    = 1'b1;
        rst_n    = 1'b0;
        waitCycles(1);
        rst_n    = 1'b1;
    endtask

    initial begin
        // Reset state (checked before any clock edge)
        #3;
        checkOutput("rst_state", state, 3'd0);
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_strobes", {mem_req, mem_we, alu_en, reg_wr_en, dma_hlda, fault}, 6'b0);
        checkOutput("rst_addr", mem_addr, 8'h00);
        checkOutput("rst_opcode", opcode, 6'h00);
        doReset();

        // Test 1: load with writeback, zero-wait memory
        $display("[TB] load with writeback");
        mem_rdata = 32'h0000_1234;
        applyStimulus(1'b1, 1'b0, 20'hF1006, 8'h22);
        waitCycles(1);
        checkOutput("t1_fetch_state", state, 3'd1);
        checkOutput("t1_fetch_bus", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
        waitCycles(1);
        checkOutput("t1_decode_state", state, 3'd2);
        checkOutput("t1_ir", ir, 32'h0000_1234);
        checkOutput("t1_pc", pc, 8'h01);
        checkOutput("t1_opcode", opcode, 6'h00);
        waitCycles(1);
        checkOutput("t1_exec", {state, alu_en}, {3'd3, 1'b1});
        waitCycles(1);
        checkOutput("t1_mem_state", state, 3'd4);
        checkOutput("t1_mem_bus", {mem_req, mem_we, mem_addr, alu_en}, {1'b1, 1'b0, 8'h22, 1'b0});
        waitCycles(1);
        checkOutput("t1_wb", {state, reg_wr_en, mem_req}, {3'd5, 1'b1, 1'b0});
        waitCycles(1);
        checkOutput("t1_next_fetch", {state, reg_wr_en, mem_addr}, {3'd1, 1'b0, 8'h01});

        // Test 2: store with three wait cycles
        $display("[TB] store with wait states");
        doReset();
        applyStimulus(1'b1, 1'b0, 20'h00100, 8'h40);
        waitCycles(3);
        checkOutput("t2_exec_state", state, 3'd3);
        ackDelay = 3;
        waitCycles(1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_mem_cycle%0d", i),
                        {state, mem_req, mem_we, mem_addr, reg_wr_en},
                        {3'd4, 1'b1, 1'b1, 8'h40, 1'b0});
            waitCycles(1);
        end
        checkOutput("t2_next_fetch", {state, mem_addr, reg_wr_en}, {3'd1, 8'h01, 1'b0});

        // Test 3: DMA hold raised during EXEC
        $display("[TB] DMA hold at boundary");
        doReset();
        mem_rdata = 32'hA800_00FF;
        applyStimulus(1'b1, 1'b0, 20'h00006, 8'h00);
        waitCycles(2);
        checkOutput("t3_opcode", opcode, 6'h2A);
        waitCycles(1);
        checkOutput("t3_exec", {state, alu_en}, {3'd3, 1'b1});
        applyStimulus(1'b1, 1'b1, 20'h00006, 8'h00);
        waitCycles(1);
        checkOutput("t3_wb_no_preempt", {state, reg_wr_en, dma_hlda}, {3'd5, 1'b1, 1'b0});
        waitCycles(1);
        checkOutput("t3_hold", {state, dma_hlda, mem_req}, {3'd6, 1'b1, 1'b0});
        waitCycles(1);
        checkOutput("t3_hold_stay", {state, dma_hlda}, {3'd6, 1'b1});
        applyStimulus(1'b1, 1'b0, 20'h00006, 8'h00);
        waitCycles(1);
        checkOutput("t3_hlda_drop", {state, dma_hlda, mem_req}, {3'd6, 1'b0, 1'b0});
        waitCycles(1);
        checkOutput("t3_refetch", {state, mem_req, mem_addr}, {3'd1, 1'b1, 8'h01});

        // Test 6: run dropped during DECODE
        $display("[TB] run dropped mid-instruction");
        waitCycles(1);
        checkOutput("t6_decode", state, 3'd2);
        applyStimulus(1'b0, 1'b0, 20'h00006, 8'h00);
        waitCycles(1);
        checkOutput("t6_exec", state, 3'd3);
        waitCycles(1);
        checkOutput("t6_wb", {state, reg_wr_en}, {3'd5, 1'b1});
        waitCycles(1);
        checkOutput("t6_idle", {state, mem_req, pc}, {3'd0, 1'b0, 8'h02});

        // Test 5: pc wrap, using 3-cycle NOPs
        $display("[TB] pc wrap");
        applyStimulus(1'b1, 1'b0, 20'h00000, 8'h00);
        waitCycles(1);
        checkOutput("t5_first_fetch", {state, pc}, {3'd1, 8'h02});
        waitCycles(253 * 3);
        checkOutput("t5_fetch_ff", {state, pc, mem_addr}, {3'd1, 8'hFF, 8'hFF});
        waitCycles(1);
        checkOutput("t5_wrap", {state, pc}, {3'd2, 8'h00});
        waitCycles(1);
        checkOutput("t5_nop_exec", state, 3'd3);
        waitCycles(1);
        checkOutput("t5_nop_done", {state, mem_addr}, {3'd1, 8'h00});

        // Test 4: bus timeout in FETCH
        $display("[TB] bus timeout");
        doReset();
        ackOn = 1'b0;
        applyStimulus(1'b1, 1'b0, 20'h00000, 8'h00);
        waitCycles(1);
        checkOutput("t4_fetch", state, 3'd1);
        waitCycles(14);
        checkOutput("t4_before_timeout", {state, fault}, {3'd1, 1'b0});
        waitCycles(1);
        checkOutput("t4_fault", {state, fault, mem_req}, {3'd7, 1'b1, 1'b0});
        ackOn = 1'b1;
        waitCycles(3);
        checkOutput("t4_sticky", {state, fault}, {3'd7, 1'b1});
        doReset();
        checkOutput("t4_cleared", {state, fault}, {3'd0, 1'b0});

        // Test 7: asynchronous reset during MEM
        $display("[TB] async reset in MEM");
        applyStimulus(1'b1, 1'b0, 20'hF1006, 8'h5A);
        waitCycles(3);
        ackOn = 1'b0;
        waitCycles(1);
        checkOutput("t7_mem", {state, mem_req, mem_addr}, {3'd4, 1'b1, 8'h5A});
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t7_state", state, 3'd0);
        checkOutput("t7_strobes", {mem_req, mem_we, alu_en, reg_wr_en, dma_hlda, fault}, 6'b0);
        checkOutput("t7_regs", {pc, mem_addr, opcode}, {8'h00, 8'h00, 6'h00});
        checkOutput("t7_ir", ir, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
